// File: rtl/i2c_arb.sv
// rtl/i2c_arb.sv - round-robin arbiter/sequencer sharing one i2c_ctrl engine among NREQ requesters
// Write-NACK retry is compiled in when I2C_ARB_RETRY_EN is defined.
module i2c_arb #(
   parameter int NREQ      = 4,
   parameter int RETRY_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2c_strobe,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_rdwr,
   input  logic [7*NREQ-1:0] req_i2c_addr,
   input  logic [8*NREQ-1:0] req_reg_addr,
   input  logic [5*NREQ-1:0] req_len,
   input  logic [8*NREQ-1:0] req_wrdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic [7:0]        rddata,
   output logic              ctrl_enable,
   output logic [6:0]        ctrl_i2c_addr,
   output logic              ctrl_rdwr,
   output logic [7:0]        ctrl_reg_addr,
   output logic [4:0]        ctrl_reg_len,
   output logic [7:0]        ctrl_reg_wrdata,
   input  logic [7:0]        ctrl_reg_rddata,
   input  logic              ctrl_reg_done,
   input  logic              ctrl_i2c_ack
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || RETRY_MAX < 0 || RETRY_MAX > 7) begin : g_bad_param
      $error("i2c_arb: NREQ must be 2..8 and RETRY_MAX 0..7");
   end

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EVAL} state_t;
   state_t state, state_nxt;

   logic [IW-1:0] ptr;
   logic [IW-1:0] gidx;
   logic [IW-1:0] win_idx;
   logic          win_valid;
   logic [6:0]    win_i2c_addr;
   logic [7:0]    win_reg_addr;
   logic [4:0]    win_len;
   logic [7:0]    win_wrdata;
   logic          win_rdwr;
   logic          done_prev;
   logic          done_rise;
   logic          cap_ack;
   logic [7:0]    cap_rddata;
   logic          force_err;
   logic          retry_avail;
   logic          grant;
   logic          ev_ok;
   logic          ev_fail;
   logic          ev_retry;

   function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int off);
      int j;
      j = int'(base) + off;
      if (j >= NREQ) j = j - NREQ;
      return IW'(j);
   endfunction

   // Scan downward so the smallest offset from ptr is the last (winning) assignment.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[rot(ptr, k)]) begin
            win_valid = 1'b1;
            win_idx   = rot(ptr, k);
         end
      end
   end

   assign win_i2c_addr = req_i2c_addr[7*win_idx +: 7];
   assign win_reg_addr = req_reg_addr[8*win_idx +: 8];
   assign win_len      = req_len[5*win_idx +: 5];
   assign win_wrdata   = req_wrdata[8*win_idx +: 8];
   assign win_rdwr     = req_rdwr[win_idx];

   assign done_rise = ctrl_reg_done & ~done_prev;

`ifdef I2C_ARB_RETRY_EN
   logic [2:0] retry_cnt;

   always_ff @(posedge clk) begin
      if (rst)           retry_cnt <= '0;
      else if (grant)    retry_cnt <= '0;
      else if (ev_retry) retry_cnt <= retry_cnt + 3'd1;
   end

   assign retry_avail = (retry_cnt < 3'(RETRY_MAX));
`else
   assign retry_avail = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (win_valid) state_nxt = (win_len == 5'd0) ? S_EVAL : S_LAUNCH;
         S_LAUNCH: if (i2c_strobe) state_nxt = S_WAIT;
         S_WAIT:   if (done_rise) state_nxt = S_EVAL;
         S_EVAL:   state_nxt = ev_retry ? S_LAUNCH : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // The final ack slot of a read is the master's own NACK, so only writes can fail on it.
   always_comb begin
      grant    = 1'b0;
      ev_ok    = 1'b0;
      ev_fail  = 1'b0;
      ev_retry = 1'b0;
      case (state)
         S_IDLE: grant = win_valid;
         S_EVAL: begin
            if (force_err)                   ev_fail  = 1'b1;
            else if (!ctrl_rdwr && cap_ack) begin
               if (retry_avail)              ev_retry = 1'b1;
               else                          ev_fail  = 1'b1;
            end else                         ev_ok    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr             <= '0;
         gidx            <= '0;
         gnt             <= '0;
         done            <= '0;
         err             <= '0;
         rddata          <= '0;
         ctrl_enable     <= 1'b0;
         ctrl_i2c_addr   <= '0;
         ctrl_rdwr       <= 1'b0;
         ctrl_reg_addr   <= '0;
         ctrl_reg_len    <= '0;
         ctrl_reg_wrdata <= '0;
         done_prev       <= 1'b0;
         cap_ack         <= 1'b0;
         cap_rddata      <= '0;
         force_err       <= 1'b0;
      end else begin
         done        <= '0;
         err         <= '0;
         done_prev   <= ctrl_reg_done;
         ctrl_enable <= (state_nxt == S_LAUNCH);
         if (grant) begin
            gidx            <= win_idx;
            gnt             <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            ctrl_i2c_addr   <= win_i2c_addr;
            ctrl_rdwr       <= win_rdwr;
            ctrl_reg_addr   <= win_reg_addr;
            ctrl_reg_len    <= win_len;
            ctrl_reg_wrdata <= win_wrdata;
            force_err       <= (win_len == 5'd0);
         end
         if (state == S_WAIT && done_rise) begin
            cap_ack    <= ctrl_i2c_ack;
            cap_rddata <= ctrl_reg_rddata;
         end
         if (ev_ok || ev_fail) begin
            gnt <= '0;
            ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            if (ev_ok) begin
               done[gidx] <= 1'b1;
               if (ctrl_rdwr) rddata <= cap_rddata;
            end else begin
               err[gidx] <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_arb.sv
// tb/tb_i2c_arb.sv - scoreboard bench for i2c_arb with a behavioural i2c_ctrl responder
// Expected launch count follows I2C_ARB_RETRY_EN.
module tb_i2c_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        i2c_strobe;
   logic [3:0]  req, req_rdwr;
   logic [27:0] req_i2c_addr;
   logic [31:0] req_reg_addr;
   logic [19:0] req_len;
   logic [31:0] req_wrdata;
   logic [3:0]  gnt, done, err;
   logic [7:0]  rddata;
   logic        ctrl_enable;
   logic [6:0]  ctrl_i2c_addr;
   logic        ctrl_rdwr;
   logic [7:0]  ctrl_reg_addr;
   logic [4:0]  ctrl_reg_len;
   logic [7:0]  ctrl_reg_wrdata;
   logic [7:0]  ctrl_reg_rddata;
   logic        ctrl_reg_done;
   logic        ctrl_i2c_ack;

   i2c_arb #(.NREQ(4), .RETRY_MAX(3)) dut (
      .clk(clk), .rst(rst), .i2c_strobe(i2c_strobe),
      .req(req), .req_rdwr(req_rdwr), .req_i2c_addr(req_i2c_addr),
      .req_reg_addr(req_reg_addr), .req_len(req_len), .req_wrdata(req_wrdata),
      .gnt(gnt), .done(done), .err(err), .rddata(rddata),
      .ctrl_enable(ctrl_enable), .ctrl_i2c_addr(ctrl_i2c_addr), .ctrl_rdwr(ctrl_rdwr),
      .ctrl_reg_addr(ctrl_reg_addr), .ctrl_reg_len(ctrl_reg_len),
      .ctrl_reg_wrdata(ctrl_reg_wrdata), .ctrl_reg_rddata(ctrl_reg_rddata),
      .ctrl_reg_done(ctrl_reg_done), .ctrl_i2c_ack(ctrl_i2c_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [28:0] fields;
      bit          b2b;
   } gexp_t;

   typedef struct {
      bit         is_err;
      int         idx;
      logic [7:0] rd;
      int         launches;
      bit         lat_issue;
      int         issue_cyc;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         launch_total = 0;
   int         launch_base = 0;
   int         en_rises = 0;
   int         stub_rise_cyc = 0;
   int         last_pulse_cyc = 0;
   int         stub_cnt = 0;
   bit         stub_busy = 0;
   bit         stub_wr_nack = 0;
   logic [7:0] stub_rd = 8'h00;
   int         exp_launch;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // i2c_ctrl stand-in: a strobe-qualified enable starts a transfer, reg_done rises 5 cycles later and holds.
   initial begin
      i2c_strobe      = 1'b0;
      ctrl_reg_done   = 1'b0;
      ctrl_i2c_ack    = 1'b0;
      ctrl_reg_rddata = 8'h00;
      forever begin
         @(negedge clk);
         i2c_strobe = (cyc % 4 == 3);
         if (rst) begin
            stub_busy     = 0;
            ctrl_reg_done = 1'b0;
         end else if (ctrl_enable && i2c_strobe) begin
            launch_total++;
            stub_busy     = 1;
            stub_cnt      = 5;
            ctrl_reg_done = 1'b0;
         end else if (stub_busy) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               stub_busy       = 0;
               ctrl_reg_done   = 1'b1;
               ctrl_i2c_ack    = ctrl_rdwr ? 1'b1 : stub_wr_nack;
               ctrl_reg_rddata = stub_rd;
               stub_rise_cyc   = cyc;
            end
         end
      end
   end

   initial begin
      logic [3:0] prev_gnt;
      logic       prev_en;
      logic [3:0] oh;
      gexp_t      g;
      rexp_t      r;
      prev_gnt = '0;
      prev_en  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_gnt    = '0;
            prev_en     = 1'b0;
            en_rises    = 0;
            launch_base = launch_total;
         end else begin
            if (ctrl_enable && !prev_en) en_rises++;
            prev_en = ctrl_enable;
            if (gnt != 4'b0 && prev_gnt == 4'b0) begin
               if (gq.size() == 0) begin
                  check("grant_unexpected", {60'b0, gnt}, 64'h0);
               end else begin
                  g  = gq.pop_front();
                  oh = 4'b0001 << g.idx;
                  check("gnt_onehot", {60'b0, gnt}, {60'b0, oh});
                  check("ctrl_fields", {35'b0, ctrl_rdwr, ctrl_i2c_addr, ctrl_reg_addr,
                                        ctrl_reg_len, ctrl_reg_wrdata}, {35'b0, g.fields});
                  if (g.b2b) check("grant_gap", 64'(cyc - last_pulse_cyc), 64'd1);
               end
            end
            prev_gnt = gnt;
            if ((done | err) != 4'b0) begin
               if (rq.size() == 0) begin
                  check("pulse_unexpected", {56'b0, done, err}, 64'h0);
               end else begin
                  r  = rq.pop_front();
                  oh = 4'b0001 << r.idx;
                  check("pulse_vec", {56'b0, done, err},
                        r.is_err ? {56'b0, 4'b0, oh} : {56'b0, oh, 4'b0});
                  check("rddata", {56'b0, rddata}, {56'b0, r.rd});
                  check("launches", 64'(launch_total - launch_base), 64'(r.launches));
                  check("enable_rises", 64'(en_rises), 64'(r.launches));
                  check("gnt_cleared", {60'b0, gnt}, 64'h0);
                  if (r.lat_issue) check("lat_from_req", 64'(cyc - r.issue_cyc), 64'd2);
                  else             check("lat_from_done", 64'(cyc - stub_rise_cyc), 64'd2);
               end
               last_pulse_cyc = cyc;
               en_rises       = 0;
               launch_base    = launch_total;
            end
         end
      end
   end

   task automatic setup(input int i, input bit rw, input logic [6:0] a, input logic [7:0] ra,
                        input logic [4:0] l, input logic [7:0] d, input bit b2b);
      gexp_t g;
      req_rdwr[i]           = rw;
      req_i2c_addr[7*i +: 7] = a;
      req_reg_addr[8*i +: 8] = ra;
      req_len[5*i +: 5]      = l;
      req_wrdata[8*i +: 8]   = d;
      g.idx    = i;
      g.fields = {rw, a, ra, l, d};
      g.b2b    = b2b;
      gq.push_back(g);
   endtask

   task automatic expect_res(input bit e, input int i, input logic [7:0] rd, input int nl,
                             input bit li, input int ic);
      rexp_t r;
      r.is_err    = e;
      r.idx       = i;
      r.rd        = rd;
      r.launches  = nl;
      r.lat_issue = li;
      r.issue_cyc = ic;
      rq.push_back(r);
   endtask

   task automatic wait_pulse(input int i);
      bit found;
      found = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (done[i] || err[i]) begin
            found = 1;
            break;
         end
      end
      check("wait_pulse_timeout", {63'b0, found}, 64'd1);
   endtask

   initial begin
      int  l0;
      bit  seen;
`ifdef I2C_ARB_RETRY_EN
      exp_launch = 4;
`else
      exp_launch = 1;
`endif
      rst = 1'b1;
      req = '0; req_rdwr = '0; req_i2c_addr = '0; req_reg_addr = '0; req_len = '0; req_wrdata = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt_done_err", {52'b0, gnt, done, err}, 64'h0);
      check("rst_rddata", {56'b0, rddata}, 64'h0);
      check("rst_ctrl", {34'b0, ctrl_enable, ctrl_i2c_addr, ctrl_rdwr, ctrl_reg_addr,
                         ctrl_reg_len, ctrl_reg_wrdata}, 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      setup(0, 1'b0, 7'h50, 8'h10, 5'd2, 8'hA5, 1'b0);
      expect_res(1'b0, 0, 8'h00, 1, 1'b0, 0);
      req[0] = 1'b1;
      wait_pulse(0);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);

      stub_rd = 8'h5A;
      setup(1, 1'b0, 7'h21, 8'h02, 5'd1, 8'h11, 1'b0);
      setup(3, 1'b1, 7'h68, 8'h75, 5'd1, 8'h00, 1'b1);
      setup(1, 1'b0, 7'h21, 8'h02, 5'd1, 8'h11, 1'b1);
      expect_res(1'b0, 1, 8'h00, 1, 1'b0, 0);
      expect_res(1'b0, 3, 8'h5A, 1, 1'b0, 0);
      expect_res(1'b0, 1, 8'h5A, 1, 1'b0, 0);
      req[1] = 1'b1;
      req[3] = 1'b1;
      wait_pulse(1);
      wait_pulse(3);
      req[3] = 1'b0;
      wait_pulse(1);
      req[1] = 1'b0;
      repeat (3) @(negedge clk);

      stub_rd = 8'h3C;
      setup(2, 1'b1, 7'h48, 8'h00, 5'd1, 8'h00, 1'b0);
      expect_res(1'b0, 2, 8'h3C, 1, 1'b0, 0);
      req[2] = 1'b1;
      wait_pulse(2);
      req[2] = 1'b0;
      repeat (3) @(negedge clk);

      stub_wr_nack = 1'b1;
      setup(1, 1'b0, 7'h21, 8'h03, 5'd1, 8'hFF, 1'b0);
      expect_res(1'b1, 1, 8'h3C, exp_launch, 1'b0, 0);
      req[1] = 1'b1;
      wait_pulse(1);
      req[1] = 1'b0;
      stub_wr_nack = 1'b0;
      repeat (3) @(negedge clk);

      setup(0, 1'b0, 7'h50, 8'h20, 5'd0, 8'h01, 1'b0);
      expect_res(1'b1, 0, 8'h3C, 0, 1'b1, cyc);
      req[0] = 1'b1;
      wait_pulse(0);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);

      setup(2, 1'b0, 7'h48, 8'h01, 5'd1, 8'h42, 1'b0);
      req[2] = 1'b1;
      l0   = launch_total;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (launch_total != l0) begin
            seen = 1;
            break;
         end
      end
      check("launch_seen", {63'b0, seen}, 64'd1);
      setup(0, 1'b0, 7'h50, 8'h11, 5'd2, 8'h5C, 1'b0);
      setup(3, 1'b0, 7'h68, 8'h6B, 5'd1, 8'h00, 1'b1);
      expect_res(1'b0, 0, 8'h00, 1, 1'b0, 0);
      expect_res(1'b0, 3, 8'h00, 1, 1'b0, 0);
      req[0] = 1'b1;
      req[3] = 1'b1;
      @(negedge clk);
      rst    = 1'b1;
      req[2] = 1'b0;
      @(negedge clk);
      check("midrst_gnt_done_err", {52'b0, gnt, done, err}, 64'h0);
      check("midrst_rddata", {56'b0, rddata}, 64'h0);
      check("midrst_ctrl", {34'b0, ctrl_enable, ctrl_i2c_addr, ctrl_rdwr, ctrl_reg_addr,
                            ctrl_reg_len, ctrl_reg_wrdata}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_pulse(0);
      req[0] = 1'b0;
      wait_pulse(3);
      req[3] = 1'b0;

      repeat (10) @(negedge clk);
      check("grant_queue_empty", 64'(gq.size()), 64'd0);
      check("result_queue_empty", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
